// File: rtl/tree_feature_loader.sv
// Byte-stream front end for the decision tree: assembles a feature bank, lets the tree settle,
// then returns the captured class with a frame-error flag. Optional checksum byte: FRAME_CHKSUM_EN.
module tree_feature_loader #(
  parameter int NUM_FEAT   = 45,
  parameter int FEAT_W     = 8,
  parameter int CLASS_W    = 5,
  parameter int SETTLE_CYC = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  output logic [NUM_FEAT*FEAT_W-1:0]   feat_bus,
  input  logic [CLASS_W-1:0]           tree_class,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CLASS_W-1:0]           m_class,
  output logic                         m_err
);

  localparam int IDX_W = $clog2(NUM_FEAT + 1);
`ifdef FRAME_CHKSUM_EN
  localparam int LAST = NUM_FEAT;
`else
  localparam int LAST = NUM_FEAT - 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
  localparam logic [IDX_W-1:0] NF_IDX   = IDX_W'(NUM_FEAT);
  localparam logic [3:0]       SET_END  = 4'(SETTLE_CYC - 1);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [3:0]                  set_q, set_d;
  logic                        err_q, err_d;
  logic                        m_valid_q, m_valid_d;
  logic [CLASS_W-1:0]          m_class_q, m_class_d;
  logic                        m_err_q, m_err_d;
  logic [NUM_FEAT*FEAT_W-1:0]  bank_q;
  logic                        s_fire, wr_en;
`ifdef FRAME_CHKSUM_EN
  logic [7:0]                  sum_q, sum_d;
`endif

  assign s_ready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign s_fire   = s_valid && s_ready;
  assign wr_en    = s_fire && (state_q == S_LOAD) && (idx_q < NF_IDX);
  assign feat_bus = bank_q;
  assign m_valid  = m_valid_q;
  assign m_class  = m_class_q;
  assign m_err    = m_err_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    set_d     = set_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    m_err_d   = m_err_q;
`ifdef FRAME_CHKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      S_LOAD: begin
        set_d = '0;
        if (s_fire) begin
          if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
`ifdef FRAME_CHKSUM_EN
          if (idx_q < NF_IDX) sum_d = sum_q + 8'(s_data);
`endif
          if (idx_q == LAST_IDX) begin
            state_d = s_last ? S_SETTLE : S_DRAIN;
`ifdef FRAME_CHKSUM_EN
            err_d   = s_last ? (8'(s_data) != sum_q) : 1'b1;
`else
            err_d   = !s_last;
`endif
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end
      S_DRAIN: begin
        set_d = '0;
        if (s_fire && s_last) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (set_q == SET_END) begin
          m_valid_d = 1'b1;
          m_class_d = tree_class;
          m_err_d   = err_q;
          state_d   = S_RESULT;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_LOAD;
          idx_d     = '0;
`ifdef FRAME_CHKSUM_EN
          sum_d     = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      set_q     <= '0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_class_q <= '0;
      m_err_q   <= 1'b0;
`ifdef FRAME_CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      set_q     <= set_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      m_err_q   <= m_err_d;
`ifdef FRAME_CHKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Bank only changes on an accepted LOAD beat, keeping tree inputs frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_FEAT; k++) begin
        if (wr_en && (idx_q == IDX_W'(k))) bank_q[k*FEAT_W +: FEAT_W] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_tree_feature_loader.sv
// Directed scoreboard bench for tree_feature_loader; the tree is modelled by a small combinational function.
module tb_tree_feature_loader;

  localparam int NF = 45;
  localparam int FW = 8;
  localparam int CW = 5;
  localparam int SC = 1;
`ifdef FRAME_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_valid, s_ready, s_last;
  logic [FW-1:0]        s_data;
  logic [NF*FW-1:0]     feat_bus;
  logic [CW-1:0]        tree_class;
  logic                 m_valid, m_ready, m_err;
  logic [CW-1:0]        m_class;

  typedef struct {
    logic [CW-1:0] cls;
    logic          err;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  frm   [0:63];
  logic [7:0]  mbank [0:NF-1];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  tree_feature_loader #(
    .NUM_FEAT(NF), .FEAT_W(FW), .CLASS_W(CW), .SETTLE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_bus(feat_bus), .tree_class(tree_class),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err)
  );

  function automatic logic [CW-1:0] tree_fn(input logic [NF*FW-1:0] b);
    logic [7:0] s;
    s = b[7:0] + b[20*FW +: FW] + b[44*FW +: FW];
    return s[4:0] ^ b[12:8];
  endfunction

  assign tree_class = tree_fn(feat_bus);

  function automatic logic [NF*FW-1:0] mbus();
    logic [NF*FW-1:0] r;
    for (int k = 0; k < NF; k++) r[k*FW +: FW] = mbank[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [NF*FW-1:0] got, input logic [NF*FW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s got=none exp=event", tag);
  endtask

  // Drives n bytes from frm[], updates the bench bank model, and pushes the expected result.
  task automatic send(input int n, input bit with_last, input bit hold_valid);
    int         midx = 0;
    int         w;
    logic [7:0] sum = 8'h00;
    logic       err;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = frm[k];
      s_last  = with_last && (k == n - 1);
      w = 0;
      while (!s_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) fail_now("sready_wait");
      @(posedge clk);
      if (midx < NF) begin
        mbank[midx] = frm[k];
        sum = sum + frm[k];
      end
      midx++;
    end
    @(negedge clk);
    s_valid = hold_valid;
    s_data  = 8'h5A;
    s_last  = 1'b0;
    if (with_last) begin
      err = (n != NF + CHK);
      if (CHK == 1 && n == NF + CHK) err = (frm[NF] != sum);
      sbq.push_back('{cls: tree_fn(mbus()), err: err});
    end
  endtask

  // Called at the negedge right after the last byte's edge.
  task automatic get_result(input int hold);
    int   cnt = 0;
    exp_t e;
    m_ready = (hold == 0);
    while (!m_valid && cnt < 50) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("latency", cnt, SC);
    if (sbq.size() == 0) begin
      fail_now("scoreboard_empty");
      return;
    end
    e = sbq.pop_front();
    chk("m_valid", m_valid, 1'b1);
    chk("m_class", m_class, e.cls);
    chk("m_err", m_err, e.err);
    chk("bank", feat_bus, mbus());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", m_valid, 1'b1);
      chk("bp_class", m_class, e.cls);
      chk("bp_err", m_err, e.err);
      chk("bp_sready", s_ready, 1'b0);
      chk("bp_bank", feat_bus, mbus());
    end
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", m_valid, 1'b0);
    chk("post_hs_sready", s_ready, 1'b1);
    chk("post_hs_bank", feat_bus, mbus());
    m_ready = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_sready", s_ready, 1'b1);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mclass", m_class, '0);
    chk("rst_merr", m_err, 1'b0);
    chk("rst_bank", feat_bus, '0);
  endtask

  task automatic add_chksum(input int n);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < n; k++) s = s + frm[k];
    frm[n] = s;
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    for (int k = 0; k < NF; k++) mbank[k] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Nominal frame: byte k carries k+1.
    for (int k = 0; k < NF; k++) frm[k] = 8'(k + 1);
    add_chksum(NF);
    send(NF + CHK, 1'b1, 1'b0);
    get_result(0);

    // Back-pressure with s_valid held high; frame of 0xAA.
    for (int k = 0; k < NF; k++) frm[k] = 8'hAA;
    add_chksum(NF);
    send(NF + CHK, 1'b1, 1'b1);
    get_result(10);

    // Short frame: 20 bytes, slots 20..44 keep 0xAA.
    for (int k = 0; k < 20; k++) frm[k] = 8'(k + 8'h30);
    send(20, 1'b1, 1'b0);
    get_result(0);

    // Long frame: 50 bytes, overflow discarded.
    for (int k = 0; k < 50; k++) frm[k] = 8'(k + 8'h40);
    send(50, 1'b1, 1'b0);
    get_result(0);

    // Reset after 30 bytes of a frame.
    for (int k = 0; k < 30; k++) frm[k] = 8'(k + 8'h90);
    send(30, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NF; k++) mbank[k] = 8'h00;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NF; k++) frm[k] = 8'(k * 3 + 7);
    add_chksum(NF);
    send(NF + CHK, 1'b1, 1'b0);
    get_result(0);

    // All-ones frame with good checksum, then with a wrong checksum.
    for (int k = 0; k < NF; k++) frm[k] = 8'h01;
`ifdef FRAME_CHKSUM_EN
    frm[NF] = 8'h2D;
    send(NF + 1, 1'b1, 1'b0);
    get_result(0);
    frm[NF] = 8'h2C;
    send(NF + 1, 1'b1, 1'b0);
    get_result(0);
`else
    send(NF, 1'b1, 1'b0);
    get_result(0);
`endif

    if (sbq.size() != 0) fail_now("scoreboard_leftover");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tree_feature_loader.md
Name: tree_feature_loader

Overview:
- Front-end sequencer for the printed decision-tree classifiers. It receives one 8-bit feature per beat over a valid/ready byte stream and assembles a full feature vector in a register bank.
- It drives that bank in parallel onto the combinational tree, waits a configurable settle time, then captures the tree's class output.
- The captured class is returned over a valid/ready result channel together with a frame-error flag.
- Sits between the sensor/ADC byte source and the tree module; it is the producer of the tree's parallel feature interface.

Parameters:
- NUM_FEAT, 45, number of features per frame; feature k lands in bank slot k (0-based, arrival order).
- FEAT_W, 8, feature width in bits.
- CLASS_W, 5, tree class output width.
- SETTLE_CYC, 1, cycles the bank is held stable before class capture; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  input byte valid.
- s_ready  output  1  loader accepts the byte this cycle.
- s_data  input  FEAT_W  feature byte.
- s_last  input  1  last byte of frame.
- feat_bus  output  NUM_FEAT*FEAT_W  feature bank to the tree; slot k occupies bits [k*FEAT_W +: FEAT_W].
- tree_class  input  CLASS_W  combinational class from the tree.
- m_valid  output  1  result valid.
- m_ready  input  1  result consumer ready.
- m_class  output  CLASS_W  captured class.
- m_err  output  1  frame length (or checksum) error.

Behaviour:
- Reset (async assert, sync deassert in the system): state LOAD, index=0, bank all zero, s_ready=1, m_valid=0, m_class=0, m_err=0.
- A beat transfers when s_valid && s_ready. m_valid and the result registers follow the same rule on m_valid && m_ready.
- Index counter: ceil(log2(NUM_FEAT+1)) bits, never wraps. It resets to 0 on entry to LOAD.

State LOAD (s_ready=1):
- Each transfer writes s_data to slot[index], then index++.
- Transfer with index==NUM_FEAT-1 and s_last=1: err_r=0, go to SETTLE.
- Transfer with index==NUM_FEAT-1 and s_last=0: err_r=1, go to DRAIN.
- Transfer with s_last=1 and index<NUM_FEAT-1 (short frame): the byte is still written, err_r=1, go to SETTLE. Unwritten slots keep their previous values.

State DRAIN (s_ready=1):
- Bytes are discarded and the bank is not modified.
- A transfer with s_last=1 goes to SETTLE.

State SETTLE (s_ready=0):
- The counter counts SETTLE_CYC cycles.
- In the last settle cycle, capture m_class<=tree_class and m_err<=err_r, set m_valid=1, and go to RESULT.
- On an error frame the class is still captured. The consumer must ignore it when m_err=1.

State RESULT (s_ready=0):
- m_valid, m_class and m_err are held stable until m_ready.
- Cycle where m_valid && m_ready: m_valid<=0, go to LOAD, index<=0.
- s_ready rises the following cycle; there is no bypass, so no byte is accepted in the handshake cycle.

Other rules:
- feat_bus is changed only in LOAD, so the tree inputs are stable through SETTLE and RESULT.
- s_valid while s_ready=0 is held off by the source per protocol; s_data and s_last are ignored then.
- Reset asserted mid-frame or mid-result returns everything to reset values immediately. No partial result is emitted.
- Latency: last byte accepted at cycle t gives m_valid=1 at t+SETTLE_CYC.

Optional Feature:
- Macro: FRAME_CHKSUM_EN.
- Defined:
  - The frame carries NUM_FEAT+1 bytes; the final byte is a checksum and is not written to the bank.
  - A running 8-bit sum, modulo 256, of the feature bytes is kept and cleared on entry to LOAD.
  - s_last is expected on byte NUM_FEAT+1.
  - Checksum byte != sum sets err_r=1.
  - Length rules are as above, with NUM_FEAT+1 as the expected length. In a short frame, s_last terminates without a checksum compare and err_r=1.
- Undefined: no checksum byte, no checksum logic, behaviour exactly as specified above.

Test Plan:
- Nominal frame:
  - Stimulus: 45 bytes of value k+1, s_last on byte 45, m_ready=1.
  - Response: feat_bus slot0=1, slot44=45; m_valid exactly SETTLE_CYC cycles after the last byte; m_class equals the tree_class driven (e.g. 13); m_err=0.
- Back-pressure:
  - Stimulus: m_ready=0 for 10 cycles after m_valid, with s_valid held at 1.
  - Response: m_class, m_err and m_valid remain stable; s_ready=0 throughout; no bank change. The next frame starts the cycle after the handshake.
- Short frame:
  - Stimulus: s_last on byte 20 (after a prior full frame of value 0xAA).
  - Response: m_err=1; slots 20..44 still read 0xAA; state returns to LOAD.
- Long frame:
  - Stimulus: 50 bytes, s_last on byte 50.
  - Response: bytes 46..50 discarded; bank holds bytes 1..45; one result with m_err=1.
- Reset mid-frame:
  - Stimulus: rst_n low after byte 30, then a full frame.
  - Response: all outputs zero during reset; the next frame's byte 1 lands in slot0 and the result is correct with m_err=0.
- FRAME_CHKSUM_EN:
  - Stimulus: 45 bytes of 0x01 followed by checksum 0x2D.
  - Response: m_err=0.
  - Stimulus: the same frame with checksum 0x2C.
  - Response: m_err=1; bank is unchanged by the checksum byte.
